ddr5_cmd_sequencer: RTL

- Synthesizable stage downstream of the scheduler's request queue and address mapping.
- Accepts one CPU request at a time and decodes its 34-bit address into DDR5 fields.
- Emits the closed-page command sequence ACT0, ACT1, RD0/RD1 or WR0/WR1, then PRE, honouring DDR5 timing counters.
- Output fields are the same ones the scheduler writes to the command trace: channel, command, bank group, bank, row/column.

---
 rtl/ddr5_cmd_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ddr5_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: one request at a time, decoded into
// ACT0/ACT1, RD or WR pair, then PRE, spaced by tRCD/tRAS/tRTP/tWR/tRP timers.
module ddr5_cmd_sequencer #(
  parameter int unsigned T_RCD   = 39,
  parameter int unsigned T_RAS   = 76,
  parameter int unsigned T_RTP   = 18,
  parameter int unsigned T_CWL   = 38,
  parameter int unsigned T_BURST = 8,
  parameter int unsigned T_WR    = 48,
  parameter int unsigned T_RP    = 39
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [33:0] req_addr,
  input  logic [1:0]  req_op,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_addr,
  output logic        done,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT0, S_ACT1, S_WAIT_RCD, S_CAS0, S_CAS1, S_WAIT_PRE, S_PRE, S_WAIT_RP
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT0 = 3'd1;
  localparam logic [2:0] CMD_ACT1 = 3'd2;
  localparam logic [2:0] CMD_RD0  = 3'd3;
  localparam logic [2:0] CMD_RD1  = 3'd4;
  localparam logic [2:0] CMD_WR0  = 3'd5;
  localparam logic [2:0] CMD_WR1  = 3'd6;
  localparam logic [2:0] CMD_PRE  = 3'd7;

  // Timer load values clamp into the 9-bit timer range.
  function automatic logic [8:0] sat_tmr(input int unsigned v);
    if (v > 32'd511) return 9'd511;
    else return v[8:0];
  endfunction

  function automatic logic [8:0] dec_sat(input logic [8:0] t);
    return (t == 9'd0) ? 9'd0 : t - 9'd1;
  endfunction

  // Each timer is loaded so that it reads 0 in the cycle its target command may issue;
  // a phase advances when the current value is <= 1 (target is next cycle).
  localparam logic [8:0] RCD_LD = sat_tmr(T_RCD - 1);
  localparam logic [8:0] RAS_LD = sat_tmr(T_RAS - 1);
  localparam logic [8:0] RTP_LD = sat_tmr(T_RTP - 1);
  localparam logic [8:0] WR_LD  = sat_tmr(T_CWL + T_BURST + T_WR - 1);
  localparam logic [8:0] RP_LD  = sat_tmr(T_RP - 2);

  state_t      state, state_nxt;
  logic [8:0]  main_tmr, main_nxt;
  logic [8:0]  ras_tmr, ras_nxt;

  logic [15:0] row_p0;
  logic [1:0]  bank_p0;
  logic [2:0]  bg_p0;
  logic [5:0]  col_hi_p0;
  logic        ch_p0;
  logic [3:0]  col_lo_p0;
  logic        is_wr_p0;
  logic        accept;
  logic        unused_addr_bits;

  assign accept           = (state == S_IDLE) && req_valid;
  assign unused_addr_bits = ^req_addr[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      main_tmr <= 9'd0;
      ras_tmr  <= 9'd0;
    end else begin
      state    <= state_nxt;
      main_tmr <= main_nxt;
      ras_tmr  <= ras_nxt;
    end
  end

  // Request capture stage
  always_ff @(posedge clock) begin
    if (accept) begin
      row_p0    <= req_addr[33:18];
      bank_p0   <= req_addr[17:16];
      bg_p0     <= req_addr[15:13];
      col_hi_p0 <= req_addr[12:7];
      ch_p0     <= req_addr[6];
      col_lo_p0 <= req_addr[5:2];
      is_wr_p0  <= (req_op == 2'd1);
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = dec_sat(main_tmr);
    ras_nxt   = dec_sat(ras_tmr);
    case (state)
      S_IDLE:     if (req_valid) state_nxt = S_ACT0;
      S_ACT0: begin
        state_nxt = S_ACT1;
        main_nxt  = RCD_LD;
        ras_nxt   = RAS_LD;
      end
      S_ACT1, S_WAIT_RCD:
        state_nxt = (main_tmr <= 9'd1) ? S_CAS0 : S_WAIT_RCD;
      S_CAS0: begin
        state_nxt = S_CAS1;
        main_nxt  = is_wr_p0 ? WR_LD : RTP_LD;
      end
      S_CAS1, S_WAIT_PRE:
        state_nxt = ((main_tmr <= 9'd1) && (ras_tmr <= 9'd1)) ? S_PRE : S_WAIT_PRE;
      S_PRE: begin
        state_nxt = (T_RP <= 2) ? S_IDLE : S_WAIT_RP;
        main_nxt  = RP_LD;
      end
      S_WAIT_RP:  if (main_tmr <= 9'd1) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    cmd_valid   = 1'b0;
    cmd         = CMD_NOP;
    cmd_addr    = 16'd0;
    done        = 1'b0;
    cmd_channel = busy ? ch_p0   : 1'b0;
    cmd_bg      = busy ? bg_p0   : 3'd0;
    cmd_bank    = busy ? bank_p0 : 2'd0;
    case (state)
      S_ACT0: begin
        cmd_valid = 1'b1;
        cmd       = CMD_ACT0;
        cmd_addr  = row_p0;
      end
      S_ACT1: begin
        cmd_valid = 1'b1;
        cmd       = CMD_ACT1;
        cmd_addr  = row_p0;
      end
      S_CAS0: begin
        cmd_valid = 1'b1;
        cmd       = is_wr_p0 ? CMD_WR0 : CMD_RD0;
        cmd_addr  = {6'd0, col_hi_p0, col_lo_p0};
      end
      S_CAS1: begin
        cmd_valid = 1'b1;
        cmd       = is_wr_p0 ? CMD_WR1 : CMD_RD1;
        cmd_addr  = {6'd0, col_hi_p0, col_lo_p0};
      end
      S_PRE: begin
        cmd_valid = 1'b1;
        cmd       = CMD_PRE;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
